// File: rtl/module_number_entry.sv
// Keypad number entry: turns scanner level codes into one-shot key events and
// assembles decimal digits into a binary operand committed with E, cleared with C.
module module_number_entry #(
    parameter int unsigned MAX_DIGITS     = 3,
    parameter int unsigned VALUE_W        = 10,
    parameter int unsigned PRESS_CYCLES   = 1000,
    parameter int unsigned RELEASE_CYCLES = 100000
) (
    input  logic                                 clk,
    input  logic                                 n_reset,
    input  logic [3:0]                           sample,
    output logic                                 key_strobe,
    output logic [3:0]                           key_code,
    output logic [4*MAX_DIGITS-1:0]              digits_bcd,
    output logic [$clog2(MAX_DIGITS+1)-1:0]      digit_count,
    output logic [VALUE_W-1:0]                   value_out,
    output logic                                 value_valid,
    output logic                                 overflow
);

    localparam int unsigned PW = $clog2(PRESS_CYCLES + 1);
    localparam int unsigned RW = $clog2(RELEASE_CYCLES + 1);
    localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
    localparam int unsigned DW = 4 * MAX_DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONFIRM,
        ST_HELD
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [3:0]      r_cand;
    logic [PW-1:0]   r_press_cnt;
    logic [RW-1:0]   r_rel_cnt;
    logic            w_event;
    logic            w_press_done;
    logic            w_rel_done;

    logic            r_key_strobe;
    logic [3:0]      r_key_code;
    logic [DW-1:0]   r_digits;
    logic [CW-1:0]   r_count;
    logic [VALUE_W-1:0] r_acc;
    logic [VALUE_W-1:0] r_value;
    logic            r_value_valid;
    logic            r_overflow;

    logic [VALUE_W+3:0] w_mac;
    logic [DW+3:0]      w_shift;

    assign w_press_done = (r_press_cnt >= PW'(PRESS_CYCLES - 1));
    assign w_rel_done   = (r_rel_cnt >= RW'(RELEASE_CYCLES - 1));

    // State register
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    // Next-state decode; the key event fires on the edge that completes the press count
    always_comb begin
        w_state_next = r_state;
        w_event      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (sample != 4'hF) w_state_next = ST_CONFIRM;
            end
            ST_CONFIRM: begin
                if (sample == r_cand) begin
                    if (w_press_done) begin
                        w_event      = 1'b1;
                        w_state_next = ST_HELD;
                    end
                end else if (sample == 4'hF) begin
                    if (w_rel_done) w_state_next = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (sample == 4'hF && w_rel_done) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Candidate code, press and release counters (saturating)
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_cand      <= '0;
            r_press_cnt <= '0;
            r_rel_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sample != 4'hF) begin
                        r_cand      <= sample;
                        r_press_cnt <= PW'(1);
                        r_rel_cnt   <= '0;
                    end
                end
                ST_CONFIRM: begin
                    if (sample == r_cand) begin
                        if (r_press_cnt < PW'(PRESS_CYCLES)) r_press_cnt <= r_press_cnt + PW'(1);
                        r_rel_cnt <= '0;
                    end else if (sample == 4'hF) begin
                        if (r_rel_cnt < RW'(RELEASE_CYCLES)) r_rel_cnt <= r_rel_cnt + RW'(1);
                    end else begin
                        r_cand      <= sample;
                        r_press_cnt <= PW'(1);
                    end
                end
                ST_HELD: begin
                    if (sample == 4'hF) begin
                        if (r_rel_cnt < RW'(RELEASE_CYCLES)) r_rel_cnt <= r_rel_cnt + RW'(1);
                    end else begin
                        r_rel_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Digit append arithmetic, computed wide and truncated
    always_comb begin
        w_mac   = {4'h0, r_acc} * (VALUE_W + 4)'(10) + {VALUE_W'(0), r_cand};
        w_shift = {r_digits, r_cand};
    end

    // Key actions applied on the event edge; strobes appear the following cycle
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_key_strobe  <= 1'b0;
            r_key_code    <= '0;
            r_digits      <= '0;
            r_count       <= '0;
            r_acc         <= '0;
            r_value       <= '0;
            r_value_valid <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_key_strobe  <= w_event;
            r_value_valid <= 1'b0;
            if (w_event) begin
                r_key_code <= r_cand;
                if (r_cand <= 4'd9) begin
                    if (r_count < CW'(MAX_DIGITS)) begin
                        r_digits <= w_shift[DW-1:0];
                        r_acc    <= w_mac[VALUE_W-1:0];
                        r_count  <= r_count + CW'(1);
                    end else begin
                        r_overflow <= 1'b1;
                    end
                end else if (r_cand == 4'hE) begin
                    if (r_count != '0) begin
                        r_value       <= r_acc;
                        r_value_valid <= 1'b1;
                        r_acc         <= '0;
                        r_digits      <= '0;
                        r_count       <= '0;
                    end
                end else if (r_cand == 4'hC) begin
                    r_acc      <= '0;
                    r_digits   <= '0;
                    r_count    <= '0;
                    r_overflow <= 1'b0;
                end
            end
        end
    end

    assign key_strobe  = r_key_strobe;
    assign key_code    = r_key_code;
    assign digits_bcd  = r_digits;
    assign digit_count = r_count;
    assign value_out   = r_value;
    assign value_valid = r_value_valid;
    assign overflow    = r_overflow;

endmodule
